// File: rtl/axis_packet_fifo.sv
// rtl/axis_packet_fifo.sv - AXI4-Stream FIFO with tlast, occupancy/packet counters and store-and-forward mode
module axis_packet_fifo #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 16,
    parameter int PACKET_MODE       = 0,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     almost_full,
    output logic                     oversize
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LEVEL   = (AW+1)'(ALMOST_FULL_LEVEL);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    typedef enum logic {ST_NORMAL, ST_RELEASE} state_t;
    state_t state_q, state_d;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr, occ_next;
    logic [DATA_WIDTH:0] head;
    logic                wr_en, rd_en, wr_last, rd_last, full, release_active;

    assign head    = mem[rd_ptr[AW-1:0]];
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = s_axis_tvalid && s_axis_tready;
    assign rd_en   = m_axis_tvalid && m_axis_tready;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && head[DATA_WIDTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_comb begin
        occ_next = occupancy;
        if (wr_en && !rd_en) begin
            occ_next = occupancy + ONE;
        end else if (rd_en && !wr_en) begin
            occ_next = occupancy - ONE;
        end
    end

    // tready is computed from the post-edge occupancy so the filling write closes the input
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            pkt_count     <= '0;
            s_axis_tready <= 1'b0;
            almost_full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            occupancy     <= occ_next;
            s_axis_tready <= (occ_next != FULL_LEVEL);
            almost_full   <= (occupancy >= AF_LEVEL);
            case ({wr_last, rd_last})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_NORMAL;
            oversize <= 1'b0;
        end else begin
            state_q  <= state_d;
            oversize <= (state_q == ST_NORMAL) && (state_d == ST_RELEASE);
        end
    end

    // A full FIFO without a complete packet can never drain in store-and-forward; fall back to cut-through
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if ((PACKET_MODE != 0) && full && (pkt_count == '0)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rd_last) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        release_active = (state_q == ST_RELEASE);
        m_axis_tvalid  = (occupancy != '0) &&
                         ((PACKET_MODE == 0) || (pkt_count != '0) || release_active);
        m_axis_tdata   = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
        m_axis_tlast   = m_axis_tvalid && head[DATA_WIDTH];
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb/tb_axis_packet_fifo.sv - self-checking bench for axis_packet_fifo in cut-through and packet modes
module tb_axis_packet_fifo;
    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata   [2];
    logic        s_tvalid  [2];
    logic        s_tlast   [2];
    logic        s_tready  [2];
    logic [31:0] m_tdata   [2];
    logic        m_tvalid  [2];
    logic        m_tlast   [2];
    logic        m_tready  [2];
    logic [4:0]  occ       [2];
    logic [4:0]  pkt       [2];
    logic        afull     [2];
    logic        ovs       [2];

    int total = 0;
    int bad   = 0;

    // reference model: ordered word list per instance plus registered flags
    logic [32:0] ml  [2][17];
    int          mc  [2];
    logic        etr [2];
    logic        eaf [2];
    logic        eov [2];
    logic        rel [2];
    logic [32:0] rx  [2][256];
    int          rx_n  [2];
    int          ovs_n [2];

    axis_packet_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]),
        .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tready(m_tready[0]),
        .occupancy(occ[0]), .pkt_count(pkt[0]), .almost_full(afull[0]), .oversize(ovs[0])
    );

    axis_packet_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]),
        .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tready(m_tready[1]),
        .occupancy(occ[1]), .pkt_count(pkt[1]), .almost_full(afull[1]), .oversize(ovs[1])
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        int occ_m, pkt_m;
        logic mv, wr, rd, trig;
        for (int m = 0; m < 2; m++) begin
            mc[m] = 0; etr[m] = 1'b0; eaf[m] = 1'b0; eov[m] = 1'b0; rel[m] = 1'b0;
            rx_n[m] = 0; ovs_n[m] = 0;
        end
        forever begin
            @(negedge aclk);
            for (int m = 0; m < 2; m++) begin
                if (!aresetn) begin
                    mc[m] = 0; etr[m] = 1'b0; eaf[m] = 1'b0; eov[m] = 1'b0; rel[m] = 1'b0;
                end
                occ_m = mc[m];
                pkt_m = 0;
                for (int k = 0; k < occ_m; k++) pkt_m = pkt_m + int'(ml[m][k][32]);
                mv = (occ_m > 0) && (m == 0 || pkt_m > 0 || rel[m]);

                chk($sformatf("tready[%0d]", m), 64'(s_tready[m]), 64'(etr[m]));
                chk($sformatf("occupancy[%0d]", m), 64'(occ[m]), 64'(occ_m));
                chk($sformatf("pkt_count[%0d]", m), 64'(pkt[m]), 64'(pkt_m));
                chk($sformatf("almost_full[%0d]", m), 64'(afull[m]), 64'(eaf[m]));
                chk($sformatf("oversize[%0d]", m), 64'(ovs[m]), 64'(eov[m]));
                chk($sformatf("tvalid[%0d]", m), 64'(m_tvalid[m]), 64'(mv));
                if (mv) begin
                    chk($sformatf("tdata[%0d]", m), 64'(m_tdata[m]), 64'(ml[m][0][31:0]));
                    chk($sformatf("tlast[%0d]", m), 64'(m_tlast[m]), 64'(ml[m][0][32]));
                end

                if (m_tvalid[m] && m_tready[m] && rx_n[m] < 256) begin
                    rx[m][rx_n[m]] = {m_tlast[m], m_tdata[m]};
                    rx_n[m]++;
                end
                if (ovs[m]) ovs_n[m]++;

                if (aresetn) begin
                    wr   = s_tvalid[m] && etr[m];
                    rd   = mv && m_tready[m];
                    trig = (m == 1) && (occ_m == 16) && (pkt_m == 0) && !rel[m];
                    eaf[m] = (occ_m >= 12);
                    eov[m] = trig;
                    if (trig) rel[m] = 1'b1;
                    else if (rd && ml[m][0][32]) rel[m] = 1'b0;
                    if (rd) begin
                        for (int k = 0; k < 16; k++) ml[m][k] = ml[m][k+1];
                        mc[m]--;
                    end
                    if (wr) begin
                        ml[m][mc[m]] = {s_tlast[m], s_tdata[m]};
                        mc[m]++;
                    end
                    etr[m] = (mc[m] != 16);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic send(input int m, input logic [31:0] d, input logic l);
        int   n;
        logic acc;
        s_tdata[m] = d; s_tlast[m] = l; s_tvalid[m] = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = s_tready[m];
            @(posedge aclk);
            #2;
            n++;
        end
        s_tvalid[m] = 1'b0;
        s_tlast[m]  = 1'b0;
        chk($sformatf("send_accept[%0d] %0d", m, d), 64'(acc), 64'(1));
    endtask

    task automatic check_rx(input int m, input int base, input int n, input int first);
        chk($sformatf("rx_count[%0d]", m), 64'(rx_n[m] - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rx_word[%0d] %0d", m, i), 64'(rx[m][base+i]),
                64'({(i == n - 1), 32'(first + i)}));
        end
    endtask

    task automatic check_zero(input int m, input string nm);
        chk($sformatf("%s tready[%0d]", nm, m), 64'(s_tready[m]), 64'(0));
        chk($sformatf("%s tvalid[%0d]", nm, m), 64'(m_tvalid[m]), 64'(0));
        chk($sformatf("%s tdata[%0d]", nm, m), 64'(m_tdata[m]), 64'(0));
        chk($sformatf("%s tlast[%0d]", nm, m), 64'(m_tlast[m]), 64'(0));
        chk($sformatf("%s occ[%0d]", nm, m), 64'(occ[m]), 64'(0));
        chk($sformatf("%s pkt[%0d]", nm, m), 64'(pkt[m]), 64'(0));
        chk($sformatf("%s afull[%0d]", nm, m), 64'(afull[m]), 64'(0));
        chk($sformatf("%s ovs[%0d]", nm, m), 64'(ovs[m]), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, obase;
        aresetn = 1'b1;
        for (int m = 0; m < 2; m++) begin
            s_tdata[m] = '0; s_tvalid[m] = 1'b0; s_tlast[m] = 1'b0; m_tready[m] = 1'b0;
        end
        #1 aresetn = 1'b0;
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        step(3);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", 64'(s_tready[0]), 64'(0));
        @(negedge aclk);
        chk("tready_after_edge", 64'(s_tready[0]), 64'(1));
        step(1);

        // cut-through streaming, consumer always ready
        m_tready[0] = 1'b1;
        base = rx_n[0];
        for (int i = 0; i < 16; i++) begin
            send(0, 32'(i), i == 15);
            chk("t1_occ_le1", 64'(occ[0] <= 5'd1), 64'(1));
            if (i == 0) begin
                chk("t1_first_valid", 64'(m_tvalid[0]), 64'(1));
                chk("t1_first_data", 64'(m_tdata[0]), 64'(0));
            end
        end
        step(4);
        check_rx(0, base, 16, 0);

        // fill with consumer stalled, then drain
        m_tready[0] = 1'b0;
        base = rx_n[0];
        for (int i = 0; i < 16; i++) send(0, 32'(100 + i), 1'b0);
        s_tdata[0] = 32'd116; s_tvalid[0] = 1'b1;
        step(3);
        chk("t2_tready_full", 64'(s_tready[0]), 64'(0));
        chk("t2_occ_full", 64'(occ[0]), 64'(16));
        chk("t2_almost_full", 64'(afull[0]), 64'(1));
        m_tready[0] = 1'b1;
        for (int i = 16; i < 20; i++) send(0, 32'(100 + i), i == 19);
        step(25);
        check_rx(0, base, 20, 100);

        // sustained flow from a full FIFO
        m_tready[0] = 1'b0;
        base = rx_n[0];
        for (int i = 0; i < 16; i++) send(0, 32'(200 + i), 1'b0);
        m_tready[0] = 1'b1;
        for (int i = 16; i < 66; i++) begin
            send(0, 32'(200 + i), i == 65);
            chk("t3_occ_high", 64'(occ[0] >= 5'd15), 64'(1));
        end
        step(25);
        check_rx(0, base, 66, 200);

        // store-and-forward: nothing leaves until tlast is stored
        m_tready[1] = 1'b1;
        base = rx_n[1];
        for (int i = 0; i < 5; i++) begin
            send(1, 32'(300 + i), i == 4);
            if (i < 4) begin
                chk("t4_held_valid", 64'(m_tvalid[1]), 64'(0));
                chk("t4_held_pkt", 64'(pkt[1]), 64'(0));
                step(2);
            end else begin
                chk("t4_release_valid", 64'(m_tvalid[1]), 64'(1));
                chk("t4_release_pkt", 64'(pkt[1]), 64'(1));
                chk("t4_release_data", 64'(m_tdata[1]), 64'(300));
            end
        end
        step(6);
        chk("t4_pkt_drained", 64'(pkt[1]), 64'(0));
        check_rx(1, base, 5, 300);

        // oversize packet forces deadlock release
        base  = rx_n[1];
        obase = ovs_n[1];
        for (int i = 0; i < 20; i++) send(1, 32'(400 + i), i == 19);
        step(30);
        chk("t5_oversize_pulses", 64'(ovs_n[1] - obase), 64'(1));
        check_rx(1, base, 20, 400);

        // reset in the middle of partial packets
        m_tready[0] = 1'b0;
        m_tready[1] = 1'b0;
        for (int i = 0; i < 7; i++) send(0, 32'(500 + i), 1'b0);
        for (int i = 0; i < 7; i++) send(1, 32'(600 + i), 1'b0);
        chk("t6_occ_before", 64'(occ[0]), 64'(7));
        chk("t6_valid_before", 64'(m_tvalid[0]), 64'(1));
        aresetn = 1'b0;
        #1;
        check_zero(0, "midreset");
        check_zero(1, "midreset");
        step(2);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("t6_occ_after", 64'(occ[0]), 64'(0));
        chk("t6_pkt_after", 64'(pkt[1]), 64'(0));
        step(1);
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        base = rx_n[0];
        for (int i = 0; i < 4; i++) send(0, 32'(700 + i), i == 3);
        step(5);
        check_rx(0, base, 4, 700);
        base = rx_n[1];
        for (int i = 0; i < 4; i++) send(1, 32'(800 + i), i == 3);
        step(8);
        check_rx(1, base, 4, 800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
